// File: rtl/io_sequencer_pkg.sv
// Shared types for the I/O instruction sequencer: FSM state encoding,
// op request vector and the fixed op priority order (IN > DELAY > OUT).
package io_sequencer_pkg;

  localparam int unsigned SW_W_DEF       = 16;
  localparam int unsigned DATA_W_DEF     = 32;
  localparam int unsigned DEB_CYCLES_DEF = 4;
  localparam int unsigned TICK_DIV_DEF   = 1000;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_IN_PRESS = 3'd1,
    ST_IN_REL   = 3'd2,
    ST_DLY_RUN  = 3'd3,
    ST_DONE     = 3'd4
  } state_e;

  // One bit per multi-cycle/single-cycle I/O op, MSB first in priority order
  typedef struct packed {
    logic in_op;
    logic dly_op;
    logic out_op;
  } op_vec_t;

  typedef enum logic [1:0] {
    SEL_NONE  = 2'd0,
    SEL_IN    = 2'd1,
    SEL_DELAY = 2'd2,
    SEL_OUT   = 2'd3
  } op_sel_e;

  // Highest-priority requested op; lower ones are ignored this cycle
  function automatic op_sel_e pick_op(input op_vec_t req);
    op_sel_e sel;
    sel = SEL_NONE;
    if (req.in_op)       sel = SEL_IN;
    else if (req.dly_op) sel = SEL_DELAY;
    else if (req.out_op) sel = SEL_OUT;
    return sel;
  endfunction

endpackage

// File: rtl/button_debouncer.sv
// ENT pushbutton conditioner: 2-flop synchronizer followed by a debouncer
// that accepts a level change only after DEB_CYCLES consecutive samples
// differ from the current debounced level.
// Ports: clk, reset (async active-low), raw (async button, pressed=0),
//        db_level (debounced level, 1 = released).
module button_debouncer #(
  parameter int unsigned DEB_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic db_level
);

  localparam int unsigned CNT_W = $clog2(DEB_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic             sync_meta;
  logic             sync_q;
  logic [CNT_W-1:0] cnt;

  // Synchronizer resets to "released" so no phantom press after reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_meta <= 1'b1;
      sync_q    <= 1'b1;
    end else begin
      sync_meta <= raw;
      sync_q    <= sync_meta;
    end
  end

  // Any sample matching the current level restarts the stability count
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt      <= '0;
      db_level <= 1'b1;
    end else if (sync_q == db_level) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      cnt      <= '0;
      db_level <= sync_q;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/io_sequencer.sv
// Sequences the multi-cycle I/O instructions IN, DELAY and OUT and drives
// the stall/done handshake that holds and advances the PC.
// Ports: clk, reset (async active-low); op_in/op_delay/op_out decoded op
//        levels; delay_val/out_val from register d0; ent raw button;
//        switch raw switches; stall, done, in_data/in_valid (IN write-back),
//        disp_data/disp_load (7-seg word). All outputs registered.
module io_sequencer
  import io_sequencer_pkg::*;
#(
  parameter int unsigned SW_W       = SW_W_DEF,
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEF,
  parameter int unsigned TICK_DIV   = TICK_DIV_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              op_in,
  input  logic              op_delay,
  input  logic              op_out,
  input  logic [DATA_W-1:0] delay_val,
  input  logic [DATA_W-1:0] out_val,
  input  logic              ent,
  input  logic [SW_W-1:0]   switch,
  output logic              stall,
  output logic              done,
  output logic [SW_W-1:0]   in_data,
  output logic              in_valid,
  output logic [DATA_W-1:0] disp_data,
  output logic              disp_load
);

  localparam int unsigned TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

  state_e            state;
  logic [DATA_W-1:0] cnt;
  logic [TICK_W-1:0] tick;
  op_vec_t           blk;
  op_vec_t           req;
  op_vec_t           elig;
  op_sel_e           sel;
  logic              db_level;
  logic              db_prev;
  logic              ent_fall;
  logic [SW_W-1:0]   sw_meta;
  logic [SW_W-1:0]   sw_sync;

  button_debouncer #(
    .DEB_CYCLES(DEB_CYCLES)
  ) u_ent_db (
    .clk      (clk),
    .reset    (reset),
    .raw      (ent),
    .db_level (db_level)
  );

  // Switch synchronizer for the IN capture
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sw_meta <= '0;
      sw_sync <= '0;
    end else begin
      sw_meta <= switch;
      sw_sync <= sw_meta;
    end
  end

  // An op that completed stays blocked until it has been seen low
  assign req      = {op_in, op_delay, op_out};
  assign elig     = op_vec_t'(req & ~blk);
  assign sel      = pick_op(elig);
  assign ent_fall = db_prev & ~db_level;

  // Sequencer FSM with registered handshake outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      stall     <= 1'b0;
      done      <= 1'b0;
      in_valid  <= 1'b0;
      disp_load <= 1'b0;
      in_data   <= '0;
      disp_data <= '0;
      cnt       <= '0;
      tick      <= '0;
      blk       <= '0;
      db_prev   <= 1'b1;
    end else begin
      done      <= 1'b0;
      in_valid  <= 1'b0;
      disp_load <= 1'b0;
      db_prev   <= db_level;
      blk       <= op_vec_t'(blk & req);
      case (state)
        ST_IDLE: begin
          stall <= 1'b0;
          case (sel)
            SEL_IN: begin
              state <= ST_IN_PRESS;
              stall <= 1'b1;
            end
            SEL_DELAY: begin
              if (delay_val == '0) begin
                state      <= ST_DONE;
                done       <= 1'b1;
                blk.dly_op <= 1'b1;
              end else begin
                cnt   <= delay_val;
                tick  <= '0;
                state <= ST_DLY_RUN;
                stall <= 1'b1;
              end
            end
            SEL_OUT: begin
              disp_data  <= out_val;
              disp_load  <= 1'b1;
              done       <= 1'b1;
              blk.out_op <= 1'b1;
            end
            default: ;
          endcase
        end
        // Only a falling edge counts, so a button held on entry is ignored
        ST_IN_PRESS: begin
          if (!op_in) begin
            state <= ST_IDLE;
            stall <= 1'b0;
          end else if (ent_fall) begin
            state <= ST_IN_REL;
          end
        end
        ST_IN_REL: begin
          if (!op_in) begin
            state <= ST_IDLE;
            stall <= 1'b0;
          end else if (db_level) begin
            in_data   <= sw_sync;
            state     <= ST_DONE;
            stall     <= 1'b0;
            done      <= 1'b1;
            in_valid  <= 1'b1;
            blk.in_op <= 1'b1;
          end
        end
        // cnt is nonzero on entry; leave when the last tick of count 1 expires
        ST_DLY_RUN: begin
          if (!op_delay) begin
            state <= ST_IDLE;
            stall <= 1'b0;
          end else if (tick == TICK_LAST) begin
            tick <= '0;
            cnt  <= cnt - DATA_W'(1);
            if (cnt == DATA_W'(1)) begin
              state      <= ST_DONE;
              stall      <= 1'b0;
              done       <= 1'b1;
              blk.dly_op <= 1'b1;
            end
          end else begin
            tick <= tick + TICK_W'(1);
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          stall <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
          stall <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_io_sequencer.sv
module tb_io_sequencer;

  localparam int unsigned SW_W       = 16;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned DEB_CYCLES = 4;
  localparam int unsigned TICK_DIV   = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              op_in = 1'b0;
  logic              op_delay = 1'b0;
  logic              op_out = 1'b0;
  logic [DATA_W-1:0] delay_val = '0;
  logic [DATA_W-1:0] out_val = '0;
  logic              ent = 1'b1;
  logic [SW_W-1:0]   switch = '0;
  logic              stall;
  logic              done;
  logic [SW_W-1:0]   in_data;
  logic              in_valid;
  logic [DATA_W-1:0] disp_data;
  logic              disp_load;

  int total = 0;
  int bad   = 0;

  io_sequencer #(
    .SW_W(SW_W), .DATA_W(DATA_W), .DEB_CYCLES(DEB_CYCLES), .TICK_DIV(TICK_DIV)
  ) dut (
    .clk(clk), .reset(reset), .op_in(op_in), .op_delay(op_delay), .op_out(op_out),
    .delay_val(delay_val), .out_val(out_val), .ent(ent), .switch(switch),
    .stall(stall), .done(done), .in_data(in_data), .in_valid(in_valid),
    .disp_data(disp_data), .disp_load(disp_load)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({stall, done, in_valid, disp_load} !== 4'b0000) begin
      bad++; $display("FAIL reset_flags: got %b want 0000", {stall, done, in_valid, disp_load});
    end
    total++;
    if (in_data !== 16'h0 || disp_data !== 32'h0) begin
      bad++; $display("FAIL reset_data: got in_data=%h disp_data=%h want 0/0", in_data, disp_data);
    end
    reset = 1'b1;
    step();
  endtask

  task automatic test_out();
    int n;
    out_val = 32'h0000_1234; op_out = 1'b1;
    step();
    total++;
    if ({stall, done, disp_load} !== 3'b011) begin
      bad++; $display("FAIL out_flags: got stall/done/load=%b want 011", {stall, done, disp_load});
    end
    total++;
    if (disp_data !== 32'h0000_1234) begin
      bad++; $display("FAIL out_data: got %h want 00001234", disp_data);
    end
    op_out = 1'b0;
    step();
    total++;
    if ({done, disp_load} !== 2'b00) begin
      bad++; $display("FAIL out_pulse_width: got done/load=%b want 00", {done, disp_load});
    end
    // Held op completes only once
    out_val = 32'h0000_5678; op_out = 1'b1; n = 0;
    repeat (4) begin step(); if (done) n++; end
    total++;
    if (n != 1 || disp_data !== 32'h0000_5678) begin
      bad++; $display("FAIL out_held: got dones=%0d data=%h want 1/00005678", n, disp_data);
    end
    op_out = 1'b0; step();
    op_out = 1'b1; step();
    total++;
    if (done !== 1'b1) begin
      bad++; $display("FAIL out_reaccept: got done=%b want 1", done);
    end
    op_out = 1'b0; step();
  endtask

  task automatic test_in();
    int errs, lat;
    bit got;
    switch = 16'hA5C3; ent = 1'b1; op_in = 1'b1;
    step();
    total++;
    if ({stall, done} !== 2'b10) begin
      bad++; $display("FAIL in_start: got stall/done=%b want 10", {stall, done});
    end
    ent = 1'b0; errs = 0;
    repeat (10) begin step(); if (stall !== 1'b1 || done !== 1'b0) errs++; end
    ent = 1'b1; got = 0; lat = 0;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (done) begin got = 1; lat = k; break; end
      if (stall !== 1'b1) errs++;
    end
    total++;
    if (errs != 0) begin
      bad++; $display("FAIL in_stall_hold: got %0d bad cycles want 0", errs);
    end
    total++;
    if (!got || lat < int'(DEB_CYCLES) + 2 || lat > int'(DEB_CYCLES) + 4) begin
      bad++; $display("FAIL in_latency: got done=%0d after %0d cycles want 1 after 6..8", got, lat);
    end
    total++;
    if ({in_valid, stall} !== 2'b10 || in_data !== 16'hA5C3) begin
      bad++; $display("FAIL in_capture: got valid/stall=%b data=%h want 10/a5c3", {in_valid, stall}, in_data);
    end
    op_in = 1'b0;
    step();
    total++;
    if ({done, in_valid} !== 2'b00) begin
      bad++; $display("FAIL in_pulse_width: got done/valid=%b want 00", {done, in_valid});
    end
    step();
  endtask

  task automatic test_bounce();
    int errs, dn;
    bit got;
    switch = 16'h3C5A; ent = 1'b1; op_in = 1'b1; errs = 0;
    step();
    ent = 1'b0; step(); if (stall !== 1'b1 || done) errs++;
    ent = 1'b1; step(); if (stall !== 1'b1 || done) errs++;
    ent = 1'b0; step(); if (stall !== 1'b1 || done) errs++;
    ent = 1'b1;
    repeat (12) begin step(); if (stall !== 1'b1 || done) errs++; end
    total++;
    if (errs != 0) begin
      bad++; $display("FAIL bounce_ignored: got %0d bad cycles want 0", errs);
    end
    op_in = 1'b0; step();
    total++;
    if ({stall, done} !== 2'b00) begin
      bad++; $display("FAIL bounce_abort: got stall/done=%b want 00", {stall, done});
    end
    // Button already held when the op starts
    ent = 1'b0; repeat (10) step();
    op_in = 1'b1; dn = 0;
    repeat (12) begin step(); if (done) dn++; end
    total++;
    if (dn != 0 || stall !== 1'b1) begin
      bad++; $display("FAIL held_entry: got dones=%0d stall=%b want 0/1", dn, stall);
    end
    ent = 1'b1; dn = 0;
    repeat (12) begin step(); if (done) dn++; end
    total++;
    if (dn != 0) begin
      bad++; $display("FAIL held_release: got dones=%0d want 0", dn);
    end
    ent = 1'b0; dn = 0;
    repeat (12) begin step(); if (done) dn++; end
    total++;
    if (dn != 0) begin
      bad++; $display("FAIL held_repress: got dones=%0d want 0", dn);
    end
    ent = 1'b1; got = 0;
    for (int k = 0; k < 20; k++) begin step(); if (done) begin got = 1; break; end end
    total++;
    if (!got || in_data !== 16'h3C5A) begin
      bad++; $display("FAIL held_final: got done=%0d data=%h want 1/3c5a", got, in_data);
    end
    op_in = 1'b0; step(); step();
  endtask

  task automatic test_delay();
    int ns, dcyc, dn;
    bit got;
    delay_val = 32'd3; op_delay = 1'b1; ns = 0; dcyc = 0; got = 0;
    for (int k = 1; k <= 40; k++) begin
      step();
      if (done) begin got = 1; dcyc = k; break; end
      if (stall) ns++;
      if (k == 2) delay_val = 32'd100;
    end
    total++;
    if (ns != 12) begin
      bad++; $display("FAIL delay_stall_len: got %0d want 12", ns);
    end
    total++;
    if (!got || dcyc != 13 || stall !== 1'b0) begin
      bad++; $display("FAIL delay_done: got done=%0d cycle=%0d stall=%b want 1/13/0", got, dcyc, stall);
    end
    op_delay = 1'b0; step();
    delay_val = 32'd0; op_delay = 1'b1;
    step();
    total++;
    if ({done, stall} !== 2'b10) begin
      bad++; $display("FAIL delay_zero: got done/stall=%b want 10", {done, stall});
    end
    dn = 0;
    repeat (3) begin step(); if (done || stall) dn++; end
    total++;
    if (dn != 0) begin
      bad++; $display("FAIL delay_held: got %0d active cycles want 0", dn);
    end
    op_delay = 1'b0; step();
  endtask

  task automatic test_abort();
    int dn;
    delay_val = 32'd5; op_delay = 1'b1;
    repeat (6) step();
    total++;
    if (stall !== 1'b1) begin
      bad++; $display("FAIL abort_running: got stall=%b want 1", stall);
    end
    op_delay = 1'b0;
    step();
    total++;
    if ({stall, done} !== 2'b00) begin
      bad++; $display("FAIL abort_exit: got stall/done=%b want 00", {stall, done});
    end
    dn = 0;
    repeat (30) begin step(); if (done || stall) dn++; end
    total++;
    if (dn != 0) begin
      bad++; $display("FAIL abort_quiet: got %0d active cycles want 0", dn);
    end
  endtask

  task automatic test_priority();
    int dl;
    out_val = 32'hDEAD_BEEF; ent = 1'b1; op_in = 1'b1; op_out = 1'b1;
    step();
    total++;
    if ({stall, done, disp_load} !== 3'b100 || disp_data !== 32'h0000_5678) begin
      bad++; $display("FAIL priority: got stall/done/load=%b data=%h want 100/00005678",
                      {stall, done, disp_load}, disp_data);
    end
    dl = 0;
    repeat (3) begin step(); if (disp_load) dl++; end
    total++;
    if (dl != 0 || disp_data !== 32'h0000_5678) begin
      bad++; $display("FAIL priority_hold: got loads=%0d data=%h want 0/00005678", dl, disp_data);
    end
    op_in = 1'b0; op_out = 1'b0; step(); step();
  endtask

  task automatic test_reset_mid();
    int dn;
    switch = 16'h0F0F; ent = 1'b1; op_in = 1'b1;
    step();
    ent = 1'b0;
    repeat (10) step();
    total++;
    if (stall !== 1'b1 || in_data !== 16'h3C5A) begin
      bad++; $display("FAIL rst_pre: got stall=%b data=%h want 1/3c5a", stall, in_data);
    end
    #2 reset = 1'b0;
    #1;
    total++;
    if ({stall, done, in_valid, disp_load} !== 4'b0000 || in_data !== 16'h0 || disp_data !== 32'h0) begin
      bad++; $display("FAIL rst_async: got flags=%b in=%h disp=%h want 0000/0/0",
                      {stall, done, in_valid, disp_load}, in_data, disp_data);
    end
    ent = 1'b1; op_in = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    dn = 0;
    repeat (10) begin step(); if (done || stall || in_valid) dn++; end
    total++;
    if (dn != 0 || in_data !== 16'h0) begin
      bad++; $display("FAIL rst_quiet: got active=%0d data=%h want 0/0", dn, in_data);
    end
    out_val = 32'h0000_00AB; op_out = 1'b1;
    step();
    total++;
    if ({done, disp_load} !== 2'b11 || disp_data !== 32'h0000_00AB) begin
      bad++; $display("FAIL rst_idle: got done/load=%b data=%h want 11/000000ab", {done, disp_load}, disp_data);
    end
    op_out = 1'b0; step();
  endtask

  initial begin
    test_reset();
    test_out();
    test_in();
    test_bounce();
    test_delay();
    test_abort();
    test_priority();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
